hba_master: RTL and testbench
=============================

HBA_MASTER -- requirements
Module: hba_master

Interface
REQ-001 Parameter DBUS_WIDTH, default 8, data bus width.
REQ-002 Parameter PERIPH_ADDR_WIDTH, default 4, peripheral-select address bits.
REQ-003 Parameter REG_ADDR_WIDTH, default 8, register address bits.
REQ-004 Parameter ADDR_WIDTH, default PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, full address width.
REQ-005 Parameter TIMEOUT_CYCLES, default 255, maximum cycles waiting for xferack (1..65535).
REQ-006 hba_clk  input  1  sole clock, all logic on rising edge.
REQ-007 hba_reset  input  1  asynchronous, active-high reset.
REQ-008 cmd_valid  input  1  command request present.
REQ-009 cmd_ready  output  1  master can accept a command.
REQ-010 cmd_rnw  input  1  1=read, 0=write.
REQ-011 cmd_addr  input  ADDR_WIDTH  target address, peripheral in upper bits.
REQ-012 cmd_wdata  input  DBUS_WIDTH  write data.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumed.
REQ-015 rsp_rdata  output  DBUS_WIDTH  read data, 0 for writes and errors.
REQ-016 rsp_err  output  1  transfer timed out.
REQ-017 hba_select  output  1  transfer in progress on bus.
REQ-018 hba_rnw  output  1  bus direction.
REQ-019 hba_abus  output  ADDR_WIDTH  bus address.
REQ-020 hba_dbus  output  DBUS_WIDTH  master write data.
REQ-021 hba_dbus_slave  input  DBUS_WIDTH  OR of all slave data buses.
REQ-022 hba_xferack_slave  input  1  OR of all slave acks.

Function
REQ-023 FSM states IDLE, XFER, RESP; all bus and rsp outputs SHALL be registered.
REQ-024 IDLE: cmd_ready=1, hba_select=0, hba_abus=0, hba_dbus=0, hba_rnw=0.
REQ-025 IDLE & cmd_valid: latch rnw/addr/wdata, next cycle enter XFER with hba_select=1 (1-cycle command-to-select latency).
REQ-026 XFER: cmd_ready=0; hba_abus, hba_rnw held stable; hba_dbus=wdata for writes, 0 for reads.
REQ-027 XFER: 16-bit wait counter cleared on entry, increments each cycle without hba_xferack_slave.
REQ-028 XFER & hba_xferack_slave=1: capture hba_dbus_slave into rsp_rdata if read (0 if write), rsp_err=0, enter RESP; hba_select drops the next cycle.
REQ-029 XFER, counter reaches TIMEOUT_CYCLES without ack: rsp_rdata=0, rsp_err=1, enter RESP, hba_select drops.
REQ-030 Ack and timeout in the same cycle: ack wins, rsp_err=0.
REQ-031 RESP: hba_select=0, all bus outputs 0, rsp_valid=1 held with rsp_rdata/rsp_err stable until rsp_ready=1; then IDLE next cycle.
REQ-032 hba_select SHALL be low at least 2 cycles between consecutive transfers (RESP + IDLE minimum).
REQ-033 hba_xferack_slave or hba_dbus_slave activity outside XFER SHALL be ignored.
REQ-034 cmd_valid while not IDLE SHALL be ignored (no queueing; cmd_ready low).

Reset
REQ-035 hba_reset asserted SHALL immediately force IDLE, cmd_ready=1 after release, all other outputs 0, counter 0.
REQ-036 Reset mid-XFER SHALL drop hba_select asynchronously; no response issued for the aborted command.

Structure
REQ-037 Shared package hba_pkg SHALL hold the state enum, default DBUS/PERIPH/REG widths and default TIMEOUT_CYCLES.
REQ-038 Single module; no sub-module required.

Verification
REQ-039 Write addr 0x101 data 0xA5, slave acks 2 cycles after select -> select 3 cycles, abus=0x101, dbus=0xA5, rsp_valid with err=0, rdata=0x00.
REQ-040 Read addr 0x202, slave returns 0x3C with ack on first select cycle -> rsp_rdata=0x3C, err=0, select high exactly 1 cycle.
REQ-041 Read with no ack, TIMEOUT_CYCLES=10 -> select drops after 10 cycles, rsp_err=1, rdata=0x00.
REQ-042 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable 5 cycles, cmd_ready stays 0, new cmd_valid ignored.
REQ-043 Back-to-back commands with cmd_valid held high -> select gap >=2 cycles, both responses correct and in order.
REQ-044 Assert hba_reset mid-XFER -> select falls same cycle, no rsp_valid, next command completes normally.

Source files
------------

// File: rtl/hba_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : hba_pkg
// Brief  : Shared defaults and FSM state type for the HBA bus master.
// Rev    : 1.0  initial release
// ============================================================================
package hba_pkg;

  localparam int HBA_DBUS_WIDTH        = 8;
  localparam int HBA_PERIPH_ADDR_WIDTH = 4;
  localparam int HBA_REG_ADDR_WIDTH    = 8;
  localparam int HBA_TIMEOUT_CYCLES    = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } hba_state_e;

endpackage
`default_nettype wire

// File: rtl/hba_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : hba_master
// Brief  : Single-outstanding HBA bus master. Accepts one command, drives the
//          shared bus until a slave acknowledges or the wait counter expires,
//          then presents a held response until it is consumed.
// Rev    : 1.0  initial release
// ============================================================================
module hba_master
  import hba_pkg::*;
#(
  parameter int DBUS_WIDTH        = HBA_DBUS_WIDTH,
  parameter int PERIPH_ADDR_WIDTH = HBA_PERIPH_ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH    = HBA_REG_ADDR_WIDTH,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES    = HBA_TIMEOUT_CYCLES
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DBUS_WIDTH-1:0] cmd_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DBUS_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // shared bus
  output logic                  hba_select,
  output logic                  hba_rnw,
  output logic [ADDR_WIDTH-1:0] hba_abus,
  output logic [DBUS_WIDTH-1:0] hba_dbus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  input  logic                  hba_xferack_slave
);

  // The counter equals the number of un-acked XFER cycles already spent, so
  // the last permitted cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  hba_state_e            r_state;
  logic                  r_cmd_ready;
  logic                  r_select;
  logic                  r_rnw;
  logic [ADDR_WIDTH-1:0] r_abus;
  logic [DBUS_WIDTH-1:0] r_dbus;
  logic                  r_rsp_valid;
  logic [DBUS_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic [15:0]           r_cnt;

  logic                  w_timeout;

  // Timeout fires on the last allowed cycle; an ack in that cycle still wins.
  assign w_timeout = (r_cnt == c_TIMEOUT_LAST);

  // Control FSM with all bus and response outputs held in registers.
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_select    <= 1'b0;
      r_rnw       <= 1'b0;
      r_abus      <= '0;
      r_dbus      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_state     <= ST_XFER;
            r_cmd_ready <= 1'b0;
            r_select    <= 1'b1;
            r_rnw       <= cmd_rnw;
            r_abus      <= cmd_addr;
            // Reads never drive write data onto the shared bus.
            r_dbus      <= cmd_rnw ? '0 : cmd_wdata;
            r_cnt       <= '0;
          end
        end
        ST_XFER: begin
          if (hba_xferack_slave || w_timeout) begin
            r_state     <= ST_RESP;
            r_select    <= 1'b0;
            r_rnw       <= 1'b0;
            r_abus      <= '0;
            r_dbus      <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            if (hba_xferack_slave) begin
              r_rsp_rdata <= r_rnw ? hba_dbus_slave : '0;
              r_rsp_err   <= 1'b0;
            end else begin
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_select    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign hba_select = r_select;
  assign hba_rnw    = r_rnw;
  assign hba_abus   = r_abus;
  assign hba_dbus   = r_dbus;

endmodule
`default_nettype wire

// File: tb/tb_hba_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_hba_master
// Brief  : Self-checking bench for hba_master (table vectors, random
//          transactions against a transaction-level model, reset abort).
// Rev    : 1.0  initial release
// ============================================================================
module tb_hba_master;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int T  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_rnw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          hba_select, hba_rnw;
  logic [AW-1:0] hba_abus;
  logic [DW-1:0] hba_dbus, hba_dbus_slave;
  logic          hba_xferack_slave;

  int checks   = 0;
  int failures = 0;

  hba_master #(
    .DBUS_WIDTH(DW), .PERIPH_ADDR_WIDTH(4), .REG_ADDR_WIDTH(8),
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
  ) dut (
    .hba_clk(clk), .hba_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hba_select(hba_select), .hba_rnw(hba_rnw), .hba_abus(hba_abus),
    .hba_dbus(hba_dbus), .hba_dbus_slave(hba_dbus_slave),
    .hba_xferack_slave(hba_xferack_slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: an ack seen on XFER cycle d (0-based) ends the
  // transfer after d+1 select cycles unless the timeout window of T cycles
  // has closed; a tie on the last cycle goes to the ack.
  task automatic model(input bit rnw, input int d, input logic [DW-1:0] sd,
                       output int sel, output logic [DW-1:0] rd, output bit err);
    if (d >= 0 && d < T) begin
      sel = d + 1;
      rd  = rnw ? sd : '0;
      err = 1'b0;
    end else begin
      sel = T;
      rd  = '0;
      err = 1'b1;
    end
  endtask

  // Select must stay low at least two sampled cycles between transfers.
  int lowcnt   = 0;
  bit prev_sel = 1'b0;
  bit seen_sel = 1'b0;
  always @(negedge clk) begin
    if (hba_select && !prev_sel) begin
      if (seen_sel) begin
        checks++;
        if (lowcnt < 2) begin
          failures++;
          $display("FAIL select gap: low for %0d cycles, required >=2", lowcnt);
        end
      end
      seen_sel = 1'b1;
      lowcnt   = 0;
    end else if (!hba_select) begin
      lowcnt++;
    end
    prev_sel = hba_select;
  end

  // One full transaction; entered and left at posedge+1 with the DUT idle.
  // Junk commands and stray slave activity are driven while busy.
  task automatic run_txn(input bit rnw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int ack_dly, input logic [DW-1:0] sdata, input int rsp_wait,
                         input int exp_sel, input logic [DW-1:0] exp_rd, input bit exp_err,
                         input string tag);
    int  k;
    bit  done;
    chk({tag, " idle"}, {30'd0, cmd_ready, hba_select}, 32'h2);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk); #1;
    cmd_rnw = ~rnw; cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    k = 0; done = 1'b0;
    while (!done) begin
      chk({tag, " xfer bus"}, {9'd0, hba_select, cmd_ready, hba_rnw, hba_abus, hba_dbus},
          {9'd0, 1'b1, 1'b0, rnw, addr, (rnw ? 8'h00 : wdata)});
      hba_xferack_slave = (k == ack_dly);
      hba_dbus_slave    = (k == ack_dly) ? sdata : DW'($urandom);
      @(posedge clk); #1;
      hba_xferack_slave = 1'b0;
      if (!hba_select) begin
        done = 1'b1;
      end else begin
        k++;
        if (k > 4 * T) begin
          checks++; failures++;
          $display("FAIL %s select bound: still high after %0d cycles", tag, k);
          done = 1'b1;
        end
      end
    end
    chk({tag, " select cycles"}, 32'(k + 1), 32'(exp_sel));
    for (int i = 0; i <= rsp_wait; i++) begin
      chk({tag, " resp"}, {8'd0, rsp_valid, rsp_rdata, rsp_err, cmd_ready, hba_select, hba_rnw, hba_abus, hba_dbus},
          {8'd0, 1'b1, exp_rd, exp_err, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00});
      rsp_ready         = (i == rsp_wait);
      hba_xferack_slave = 1'($urandom);
      hba_dbus_slave    = DW'($urandom);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0; hba_xferack_slave = 1'b0; cmd_valid = 1'b0;
    chk({tag, " done"}, {19'd0, rsp_valid, cmd_ready, hba_select, rsp_rdata, rsp_err, 2'b00},
        {19'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00});
  endtask

  typedef struct {
    bit            rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_dly;
    logic [DW-1:0] sdata;
    int            rsp_wait;
    int            exp_sel;
    logic [DW-1:0] exp_rd;
    bit            exp_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int            sel, d, w;
    logic [DW-1:0] rd;
    bit            err, rnw, seen_rsp;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, sd;

    tbl[0] = '{1'b0, 12'h101, 8'hA5,  2, 8'h77, 0,  3, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 12'h202, 8'h11,  0, 8'h3C, 0,  1, 8'h3C, 1'b0};
    tbl[2] = '{1'b1, 12'h0F0, 8'h22, -1, 8'h99, 0, 10, 8'h00, 1'b1};
    tbl[3] = '{1'b1, 12'h155, 8'h33,  1, 8'hC3, 5,  2, 8'hC3, 1'b0};
    tbl[4] = '{1'b1, 12'hFFF, 8'h44,  9, 8'h81, 1, 10, 8'h81, 1'b0};
    tbl[5] = '{1'b0, 12'h800, 8'h5A, -1, 8'hEE, 2, 10, 8'h00, 1'b1};
    tbl[6] = '{1'b0, 12'h0AA, 8'hFF,  0, 8'h12, 0,  1, 8'h00, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; hba_dbus_slave = '0; hba_xferack_slave = 1'b0;
    #1;
    chk("reset outputs", {8'd0, hba_select, rsp_valid, rsp_rdata, rsp_err, hba_abus, hba_dbus, hba_rnw}, 32'h0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset ready", {30'd0, cmd_ready, hba_select}, 32'h2);

    // Directed table; consecutive entries also exercise held cmd_valid.
    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].rnw, tbl[i].addr, tbl[i].wdata, tbl[i].ack_dly, tbl[i].sdata,
              tbl[i].rsp_wait, tbl[i].exp_sel, tbl[i].exp_rd, tbl[i].exp_err, $sformatf("vec%0d", i));

    // Randomised transactions against the model.
    for (int i = 0; i < 40; i++) begin
      rnw = 1'($urandom); a = AW'($urandom); wd = DW'($urandom); sd = DW'($urandom);
      d = int'($urandom_range(0, 13));
      if (d > 10) d = -1;
      w = int'($urandom_range(0, 3));
      model(rnw, d, sd, sel, rd, err);
      run_txn(rnw, a, wd, d, sd, w, sel, rd, err, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a transfer aborts it with no response.
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 12'h3AB; cmd_wdata = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort pre-reset select", {31'd0, hba_select}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort async drop", {11'd0, hba_select, rsp_valid, hba_abus, hba_dbus}, 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("abort idle", {30'd0, cmd_ready, hba_select}, 32'h2);
    seen_rsp = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid) seen_rsp = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort no response", {31'd0, seen_rsp}, 32'h0);
    run_txn(1'b1, 12'h404, 8'h00, 3, 8'h6D, 1, 4, 8'h6D, 1'b0, "post-abort");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
